// File: rtl/multiplier8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one partial product per clock, result as hi/lo bytes with a one-cycle write strobe.
// Optional build macro MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module multiplier8_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic       wrenable,
  output logic [7:0] prod_hi,
  output logic [7:0] prod_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] acc_sum;
  logic [7:0]  mplier_shr;
  logic        last_iter;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    acc_sum    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
    mplier_shr = mplier_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
    last_iter  = (cnt_q == 3'd7) || (mplier_shr == 8'h00);
`else
    last_iter  = (cnt_q == 3'd7);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {8'h00, a};
          mplier_d = b;
          acc_d    = 16'h0000;
          cnt_d    = 3'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + 3'd1;
        if (last_iter) begin
          prod_d  = acc_sum;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state so no input reaches a port combinationally.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= 16'h0000;
      acc_q    <= 16'h0000;
      prod_q   <= 16'h0000;
      mplier_q <= 8'h00;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wrenable = done_q;
  assign prod_hi  = prod_q[15:8];
  assign prod_lo  = prod_q[7:0];

endmodule
